// File: rtl/max6675_pkg.sv
// -----------------------------------------------------------------------------
// max6675_pkg
// Shared definitions for the MAX6675 emulator: frame geometry, field positions,
// default conversion length, FSM state encodings and the frame builder.
// No ports (package).
// -----------------------------------------------------------------------------
package max6675_pkg;

    localparam int FRAME_BITS          = 16;
    localparam int TEMP_BITS           = 12;
    localparam int RESULT_BITS         = TEMP_BITS + 1;   // {temp_code, tc_open}

    // Frame field positions (MSB first on the wire). Bit 15 is the dummy sign
    // bit, bit 1 the device ID and bit 0 is always 0.
    localparam int TEMP_MSB            = 14;
    localparam int TEMP_LSB            = 3;
    localparam int OPEN_BIT            = 2;

    // 220 ms at 100 MHz, matching the real converter.
    localparam int DEFAULT_CONV_CYCLES = 22_000_000;

    // Conversion FSM states
    localparam logic [0:0] CONV_IDLE_CS_LOW = 1'b0;
    localparam logic [0:0] CONV_CONVERTING  = 1'b1;

    // Shift FSM states
    localparam logic [1:0] SHIFT_IDLE  = 2'd0;
    localparam logic [1:0] SHIFT_SHIFT = 2'd1;
    localparam logic [1:0] SHIFT_DONE  = 2'd2;

    // Build the 16-bit wire frame from a latched {temp_code, tc_open} result.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [RESULT_BITS-1:0] result
    );
        logic [FRAME_BITS-1:0] frame;
        frame                    = 16'h0000;
        frame[TEMP_MSB:TEMP_LSB] = result[RESULT_BITS-1:1];
        frame[OPEN_BIT]          = result[0];
        return frame;
    endfunction

endpackage

// File: rtl/max6675_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous input into the clk domain through a SYNC_STAGES-deep
// flip-flop chain and flags every change of the synchronised level.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset (chain and history cleared to 0)
//   async_in in  asynchronous input
//   level    out synchronised level
//   changed  out one-cycle pulse when the synchronised level changes
// The consumer derives rise/fall as changed & level / changed & ~level.
// -----------------------------------------------------------------------------
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic changed
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus one stage of history for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level   = sync_r[SYNC_STAGES-1];
    assign changed = sync_r[SYNC_STAGES-1] ^ prev_r;

endmodule

// File: rtl/max6675_emulator.sv
// -----------------------------------------------------------------------------
// max6675_emulator
// SPI mode-0 responder emulating a MAX6675 thermocouple converter. While CS is
// high a conversion free-runs and latches {i_temp_code, i_tc_open} at the end
// of each conversion period; pulling CS low aborts the running conversion and
// serves the last latched result as a 16-bit frame, MSB first, shifted on SCK
// falling edges.
// Ports:
//   i_clk        in  system clock
//   i_reset      in  synchronous active-high reset
//   i_temp_code  in  12-bit temperature code, sampled at conversion end
//   i_tc_open    in  open-thermocouple flag, sampled with i_temp_code
//   i_CS         in  chip select, active low, asynchronous
//   i_SPI_CLK    in  SCK, idle low, asynchronous
//   o_SPI_MISO   out serial data to the master
//   o_MISO_OE    out output enable for MISO (1 while a frame window is open)
//   o_conv_busy  out 1 while a conversion is running
//   o_frame_done out one-cycle pulse after the 16th bit has been shifted out
// -----------------------------------------------------------------------------
module max6675_emulator
    import max6675_pkg::*;
#(
    parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [11:0] i_temp_code,
    input  logic        i_tc_open,
    input  logic        i_CS,
    input  logic        i_SPI_CLK,
    output logic        o_SPI_MISO,
    output logic        o_MISO_OE,
    output logic        o_conv_busy,
    output logic        o_frame_done
);

    localparam int              CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    // Synchronised control inputs
    logic cs_level_s;
    logic cs_changed_s;
    logic sck_level_s;
    logic sck_changed_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic sck_fall_s;

    // Conversion side
    logic [0:0]             conv_state_r;
    logic [CNT_W-1:0]       conv_cnt_r;
    logic [RESULT_BITS-1:0] result_r;
    logic                   conv_busy_r;
    logic                   conv_done_s;
    logic [RESULT_BITS-1:0] serve_result_s;

    // Shift side
    logic [1:0]            shift_state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [4:0]            bit_cnt_r;
    logic                  miso_oe_r;
    logic                  frame_done_r;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (i_clk),
        .reset    (i_reset),
        .async_in (i_CS),
        .level    (cs_level_s),
        .changed  (cs_changed_s)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk      (i_clk),
        .reset    (i_reset),
        .async_in (i_SPI_CLK),
        .level    (sck_level_s),
        .changed  (sck_changed_s)
    );

    assign cs_rise_s  = cs_changed_s & cs_level_s;
    assign cs_fall_s  = cs_changed_s & ~cs_level_s;
    assign sck_fall_s = sck_changed_s & ~sck_level_s;

    // End-of-conversion detect; a completion coinciding with the CS fall must
    // be the value that gets served, so the frame loader sees it directly.
    always_comb begin
        conv_done_s    = 1'b0;
        serve_result_s = result_r;
        if ((conv_state_r == CONV_CONVERTING) && (conv_cnt_r == CNT_LAST)) begin
            conv_done_s    = 1'b1;
            serve_result_s = {i_temp_code, i_tc_open};
        end else begin
            conv_done_s    = 1'b0;
            serve_result_s = result_r;
        end
    end

    // Conversion FSM: free-running conversions while CS is high, abort on CS low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            conv_state_r <= CONV_IDLE_CS_LOW;
            conv_cnt_r   <= {CNT_W{1'b0}};
            result_r     <= {RESULT_BITS{1'b0}};
            conv_busy_r  <= 1'b0;
        end else begin
            case (conv_state_r)
                CONV_IDLE_CS_LOW: begin
                    conv_cnt_r <= {CNT_W{1'b0}};
                    if (cs_level_s) begin
                        conv_state_r <= CONV_CONVERTING;
                        conv_busy_r  <= 1'b1;
                    end else begin
                        conv_state_r <= CONV_IDLE_CS_LOW;
                        conv_busy_r  <= 1'b0;
                    end
                end
                CONV_CONVERTING: begin
                    if (conv_done_s) begin
                        // Completion wins over a simultaneous CS fall.
                        result_r   <= serve_result_s;
                        conv_cnt_r <= {CNT_W{1'b0}};
                        if (!cs_level_s) begin
                            conv_state_r <= CONV_IDLE_CS_LOW;
                            conv_busy_r  <= 1'b0;
                        end else begin
                            conv_state_r <= CONV_CONVERTING;
                            conv_busy_r  <= 1'b1;
                        end
                    end else if (!cs_level_s) begin
                        // Abort: old result stays valid.
                        conv_state_r <= CONV_IDLE_CS_LOW;
                        conv_cnt_r   <= {CNT_W{1'b0}};
                        conv_busy_r  <= 1'b0;
                    end else begin
                        conv_cnt_r  <= conv_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        conv_busy_r <= 1'b1;
                    end
                end
                default: begin
                    conv_state_r <= CONV_IDLE_CS_LOW;
                    conv_cnt_r   <= {CNT_W{1'b0}};
                    conv_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shift FSM: load on CS fall, shift on SCK fall, drop everything on CS rise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_state_r <= SHIFT_IDLE;
            shift_r       <= {FRAME_BITS{1'b0}};
            bit_cnt_r     <= 5'd0;
            miso_oe_r     <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (cs_rise_s) begin
                shift_state_r <= SHIFT_IDLE;
                shift_r       <= {FRAME_BITS{1'b0}};
                bit_cnt_r     <= 5'd0;
                miso_oe_r     <= 1'b0;
            end else begin
                case (shift_state_r)
                    SHIFT_IDLE: begin
                        if (cs_fall_s) begin
                            shift_r       <= build_frame(serve_result_s);
                            bit_cnt_r     <= 5'd0;
                            miso_oe_r     <= 1'b1;
                            shift_state_r <= SHIFT_SHIFT;
                        end else begin
                            miso_oe_r     <= 1'b0;
                        end
                    end
                    SHIFT_SHIFT: begin
                        if (sck_fall_s) begin
                            // Zero-fill so MISO reads 0 once the frame is out.
                            shift_r   <= {shift_r[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd15) begin
                                frame_done_r  <= 1'b1;
                                shift_state_r <= SHIFT_DONE;
                            end else begin
                                shift_state_r <= SHIFT_SHIFT;
                            end
                        end else begin
                            shift_state_r <= SHIFT_SHIFT;
                        end
                    end
                    SHIFT_DONE: begin
                        shift_state_r <= SHIFT_DONE;
                    end
                    default: begin
                        shift_state_r <= SHIFT_IDLE;
                        shift_r       <= {FRAME_BITS{1'b0}};
                        bit_cnt_r     <= 5'd0;
                        miso_oe_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_SPI_MISO   = shift_r[FRAME_BITS-1];
    assign o_MISO_OE    = miso_oe_r;
    assign o_conv_busy  = conv_busy_r;
    assign o_frame_done = frame_done_r;

endmodule

// File: tb/tb_max6675_emulator.sv
module tb_max6675_emulator;

    localparam int CONV = 100;
    localparam int HALF = 13;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [11:0] i_temp_code;
    logic        i_tc_open;
    logic        i_CS;
    logic        i_SPI_CLK;
    logic        o_SPI_MISO;
    logic        o_MISO_OE;
    logic        o_conv_busy;
    logic        o_frame_done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          done_cnt     = 0;
    logic [15:0] exp_q[$];

    max6675_emulator #(.CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_temp_code  (i_temp_code),
        .i_tc_open    (i_tc_open),
        .i_CS         (i_CS),
        .i_SPI_CLK    (i_SPI_CLK),
        .o_SPI_MISO   (o_SPI_MISO),
        .o_MISO_OE    (o_MISO_OE),
        .o_conv_busy  (o_conv_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_frame_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: drop CS, clock nbits; MISO sampled just before each SCK rise.
    // Leaves CS low. Counts bit slots where busy was high or OE was low.
    task automatic read_bits(input int nbits, output logic [31:0] data,
                             output int bad_ctrl);
        data     = 32'h0;
        bad_ctrl = 0;
        i_CS     = 1'b0;
        wait_cycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            data = {data[30:0], o_SPI_MISO};
            if (o_conv_busy !== 1'b0 || o_MISO_OE !== 1'b1) bad_ctrl++;
            i_SPI_CLK = 1'b1;
            wait_cycles(HALF);
            i_SPI_CLK = 1'b0;
            wait_cycles(HALF - 1);
        end
    endtask

    task automatic release_cs();
        i_CS = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        int          d0;
        i_reset = 1'b1; i_CS = 1'b1; i_SPI_CLK = 1'b0;
        i_temp_code = 12'h190; i_tc_open = 1'b0;
        wait_cycles(3);
        tests_run++;
        if ({o_SPI_MISO, o_MISO_OE, o_conv_busy, o_frame_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {o_SPI_MISO, o_MISO_OE, o_conv_busy, o_frame_done});
        end
        i_reset = 1'b0;
        wait_cycles(10);
        tests_run++;
        if (o_conv_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_cs_high got=%b want=1", o_conv_busy);
        end
        wait_cycles(140);
        exp_q.push_back(16'h0C80);
        d0 = done_cnt;
        read_bits(16, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[15:0] !== e) begin
            tests_failed++;
            $display("FAIL frame_0c80 got=%h want=%h", d[15:0], e);
        end
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL done_pulse_1 got=%0d want=1", done_cnt - d0);
        end
        release_cs();
    endtask

    task automatic test_open_flag();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        i_temp_code = 12'h000; i_tc_open = 1'b1;
        wait_cycles(150);
        exp_q.push_back(16'h0004);
        read_bits(16, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[15:0] !== e) begin
            tests_failed++;
            $display("FAIL frame_open got=%h want=%h", d[15:0], e);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL busy_oe_cs_low got=%0d bad slots want=0", bad);
        end
        release_cs();
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        i_temp_code = 12'h190; i_tc_open = 1'b0;
        wait_cycles(110);
        i_temp_code = 12'h3FF;
        wait_cycles(50);
        exp_q.push_back(16'h0C80);
        read_bits(16, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[15:0] !== e) begin
            tests_failed++;
            $display("FAIL abort_keeps_old got=%h want=%h", d[15:0], e);
        end
        release_cs();
    endtask

    task automatic test_overclock();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        int          d0;
        i_temp_code = 12'h2A5; i_tc_open = 1'b0;
        wait_cycles(150);
        exp_q.push_back(16'h1528);
        d0 = done_cnt;
        read_bits(24, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[23:8] !== e) begin
            tests_failed++;
            $display("FAIL frame_24clk got=%h want=%h", d[23:8], e);
        end
        tests_run++;
        if (d[7:0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL tail_bits got=%h want=00", d[7:0]);
        end
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL done_single got=%0d want=1", done_cnt - d0);
        end
        release_cs();
    endtask

    task automatic test_partial();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        int          d0;
        wait_cycles(150);
        exp_q.push_back(16'h1528);
        d0 = done_cnt;
        read_bits(8, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[7:0] !== e[15:8]) begin
            tests_failed++;
            $display("FAIL partial_bits got=%h want=%h", d[7:0], e[15:8]);
        end
        i_CS = 1'b1;
        wait_cycles(4);
        tests_run++;
        if ({o_SPI_MISO, o_MISO_OE} !== 2'b00) begin
            tests_failed++;
            $display("FAIL partial_release got=%b want=00", {o_SPI_MISO, o_MISO_OE});
        end
        tests_run++;
        if (done_cnt - d0 !== 0) begin
            tests_failed++;
            $display("FAIL partial_no_done got=%0d want=0", done_cnt - d0);
        end
        i_temp_code = 12'h7FF; i_tc_open = 1'b1;
        wait_cycles(150);
        exp_q.push_back(16'h3FFC);
        read_bits(16, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[15:0] !== e) begin
            tests_failed++;
            $display("FAIL fresh_frame got=%h want=%h", d[15:0], e);
        end
        release_cs();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [15:0] e;
        int          bad;
        wait_cycles(150);
        exp_q.push_back(16'h3FFC);
        read_bits(5, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[4:0] !== e[15:11]) begin
            tests_failed++;
            $display("FAIL pre_reset_bits got=%h want=%h", d[4:0], e[15:11]);
        end
        i_reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({o_SPI_MISO, o_MISO_OE, o_conv_busy, o_frame_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midframe_reset got=%b want=0000",
                     {o_SPI_MISO, o_MISO_OE, o_conv_busy, o_frame_done});
        end
        i_reset = 1'b0;
        i_CS    = 1'b1;
        wait_cycles(3);
        exp_q.push_back(16'h0000);
        read_bits(16, d, bad);
        e = exp_q.pop_front();
        tests_run++;
        if (d[15:0] !== e) begin
            tests_failed++;
            $display("FAIL post_reset_frame got=%h want=%h", d[15:0], e);
        end
        release_cs();
    endtask

    initial begin
        i_reset = 1'b1; i_CS = 1'b1; i_SPI_CLK = 1'b0;
        i_temp_code = 12'h000; i_tc_open = 1'b0;
        test_reset();
        test_open_flag();
        test_abort();
        test_overclock();
        test_partial();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
